// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - rounding mode codes and width helpers for the fixed-point requantiser
package fixed_pkg;

   // Rounding mode codes carried on in_mode.
   localparam logic [1:0] ROUND_TRUNC     = 2'd0;
   localparam logic [1:0] ROUND_HALF_UP   = 2'd1;
   localparam logic [1:0] ROUND_HALF_EVEN = 2'd2;
   localparam logic [1:0] ROUND_TO_ZERO   = 2'd3;

   // Input lane width: integer bits plus the doubled fraction of a product.
   function automatic int calc_iw(input int intw, input int ratw);
      return intw + 2 * ratw;
   endfunction

   // Output lane width: integer bits plus the single fraction that survives.
   function automatic int calc_ow(input int intw, input int ratw);
      return intw + ratw;
   endfunction

endpackage

// File: rtl/fixed_round_lane.sv
// rtl/fixed_round_lane.sv - per-lane rounding decision and saturating increment
module fixed_round_lane
   import fixed_pkg::*;
#(
   parameter int INTW   = 10,
   parameter int RATW   = 2,
   parameter bit SIGNED = 1'b0,
   localparam int IW    = calc_iw(INTW, RATW),
   localparam int OW    = calc_ow(INTW, RATW)
) (
   input  logic [IW-1:0] in_word,
   input  logic [1:0]    mode,
   output logic [OW-1:0] q,
   output logic          inc,
   input  logic [OW-1:0] s1_q,
   input  logic          s1_inc,
   output logic [OW-1:0] r,
   output logic          sat
);

   // Weight of exactly one half output LSB within the dropped fraction.
   localparam logic [RATW-1:0] HALF = RATW'(1) << (RATW - 1);

   // Largest representable output; the negative side can never be exceeded.
   localparam logic [OW-1:0] MAX_VAL = SIGNED ? {1'b0, {(OW - 1){1'b1}}} : {OW{1'b1}};

   // Decide whether the kept part must be bumped by one LSB for this mode.
   function automatic logic inc_decide(input logic            q_lsb,
                                       input logic [RATW-1:0] f,
                                       input logic            sign,
                                       input logic [1:0]      m);
      logic bump;
      bump = 1'b0;
      case (m)
         ROUND_TRUNC:     bump = 1'b0;
         ROUND_HALF_UP:   bump = (f >= HALF);
         ROUND_HALF_EVEN: bump = (f > HALF) || ((f == HALF) && q_lsb);
         ROUND_TO_ZERO:   bump = SIGNED && sign && (f != '0);
         default:         bump = 1'b0;
      endcase
      return bump;
   endfunction

   // Add the bump with one guard bit; clamp to MAX_VAL when it overflows.
   function automatic logic [OW:0] sat_add(input logic [OW-1:0] qv, input logic bump);
      logic [OW:0] sum;
      logic        ovf;
      sum = {(SIGNED ? qv[OW-1] : 1'b0), qv} + {{OW{1'b0}}, bump};
      ovf = SIGNED ? (sum[OW] != sum[OW-1]) : sum[OW];
      return {ovf, (ovf ? MAX_VAL : sum[OW-1:0])};
   endfunction

   // Front half feeds S1 (split + decision), back half feeds S2 (add + clamp).
   always_comb begin
      q        = in_word[IW-1:RATW];
      inc      = inc_decide(in_word[RATW], in_word[RATW-1:0], SIGNED && in_word[IW-1], mode);
      {sat, r} = sat_add(s1_q, s1_inc);
   end

endmodule

// File: rtl/fixed_round_pipe.sv
// rtl/fixed_round_pipe.sv - two-stage multi-lane requantiser with saturation counting
module fixed_round_pipe
   import fixed_pkg::*;
#(
   parameter int INTW   = 10,
   parameter int RATW   = 2,
   parameter int LANES  = 1,
   parameter bit SIGNED = 1'b0,
   parameter int CNTW   = 16,
   localparam int IW    = calc_iw(INTW, RATW),
   localparam int OW    = calc_ow(INTW, RATW)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*IW-1:0] in_data,
   input  logic [1:0]          in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*OW-1:0] out_data,
   output logic [LANES-1:0]    out_sat,
   input  logic                sat_clr,
   output logic [CNTW-1:0]     sat_count
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic                en;
   logic                s1_valid;
   logic [LANES*OW-1:0] s1_q;
   logic [LANES-1:0]    s1_inc;
   logic [LANES*OW-1:0] q_next;
   logic [LANES-1:0]    inc_next;
   logic [LANES*OW-1:0] r_next;
   logic [LANES-1:0]    sat_next;

   // Whole pipe advances together whenever the output slot is free or draining.
   always_comb begin
      en       = !out_valid || out_ready;
      in_ready = en;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      fixed_round_lane #(
         .INTW   (INTW),
         .RATW   (RATW),
         .SIGNED (SIGNED)
      ) u_lane (
         .in_word (in_data[k*IW +: IW]),
         .mode    (in_mode),
         .q       (q_next[k*OW +: OW]),
         .inc     (inc_next[k]),
         .s1_q    (s1_q[k*OW +: OW]),
         .s1_inc  (s1_inc[k]),
         .r       (r_next[k*OW +: OW]),
         .sat     (sat_next[k])
      );
   end

   // S1 captures the split value and rounding decision, so mode travels with its beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_inc   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_q     <= q_next;
         s1_inc   <= inc_next;
      end
   end

   // S2 is the output register; it holds under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         out_data  <= r_next;
         out_sat   <= sat_next;
      end
   end

   // Count delivered beats with any saturated lane; clear wins, count sticks at max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && (|out_sat) && (sat_count != CNT_MAX)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_fixed_round_pipe.sv
// tb/tb_fixed_round_pipe.sv - directed and scoreboard checks for fixed_round_pipe
module tb_fixed_round_pipe;
   import fixed_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus for the two single-lane instances
   logic        in_valid  = 1'b0;
   logic [13:0] in_data   = '0;
   logic [1:0]  in_mode   = '0;
   logic        out_ready = 1'b1;
   logic        sat_clr   = 1'b0;

   logic        u_iready, u_ovalid;
   logic [11:0] u_odata;
   logic [0:0]  u_osat;
   logic [15:0] u_cnt;
   logic        s_iready, s_ovalid;
   logic [11:0] s_odata;
   logic [0:0]  s_osat;
   logic [15:0] s_cnt;

   // four-lane signed instance
   logic        w_ivalid = 1'b0;
   logic [55:0] w_idata  = '0;
   logic [1:0]  w_mode   = '0;
   logic        w_oready = 1'b1;
   logic        w_clr    = 1'b0;
   logic        w_iready, w_ovalid;
   logic [47:0] w_odata;
   logic [3:0]  w_osat;
   logic [15:0] w_cnt;

   fixed_round_pipe #(.INTW(10), .RATW(2), .LANES(1), .SIGNED(1'b0), .CNTW(16)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_iready), .in_data(in_data),
      .in_mode(in_mode), .out_valid(u_ovalid), .out_ready(out_ready), .out_data(u_odata),
      .out_sat(u_osat), .sat_clr(sat_clr), .sat_count(u_cnt));

   fixed_round_pipe #(.INTW(10), .RATW(2), .LANES(1), .SIGNED(1'b1), .CNTW(16)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_iready), .in_data(in_data),
      .in_mode(in_mode), .out_valid(s_ovalid), .out_ready(out_ready), .out_data(s_odata),
      .out_sat(s_osat), .sat_clr(sat_clr), .sat_count(s_cnt));

   fixed_round_pipe #(.INTW(10), .RATW(2), .LANES(4), .SIGNED(1'b1), .CNTW(16)) dut_w (
      .clk(clk), .rst(rst), .in_valid(w_ivalid), .in_ready(w_iready), .in_data(w_idata),
      .in_mode(w_mode), .out_valid(w_ovalid), .out_ready(w_oready), .out_data(w_odata),
      .out_sat(w_osat), .sat_clr(w_clr), .sat_count(w_cnt));

   int n_pass   = 0;
   int n_checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   logic [11:0] u_res, s_res;
   logic        u_s, s_s;

   // one beat through the single-lane pair, checking the 2-edge latency
   task automatic run1(input logic [13:0] d, input logic [1:0] m, input logic clr, input string tag);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_mode   = m;
      out_ready = 1'b1;
      check({tag, "_rdy"}, u_iready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_mode  = ~m;
      @(negedge clk);
      check({tag, "_lat1"}, u_ovalid, 1'b0);
      @(negedge clk);
      check({tag, "_lat2"}, u_ovalid, 1'b1);
      u_res   = u_odata;
      u_s     = u_osat[0];
      s_res   = s_odata;
      s_s     = s_osat[0];
      sat_clr = clr;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
   endtask

   // independent signed reference: integer arithmetic on the real value
   function automatic logic [12:0] model_s(input logic [13:0] d, input logic [1:0] m);
      int v, q, f, res;
      logic sat;
      v   = int'($signed(d));
      q   = v >>> 2;
      f   = v & 3;
      case (m)
         2'd0:    res = q;
         2'd1:    res = (v + 2) >>> 2;
         2'd2:    res = (f == 2) ? (q + (q & 1)) : ((v + 2) >>> 2);
         default: res = v / 4;
      endcase
      sat = 1'b0;
      if (res > 2047) begin
         res = 2047;
         sat = 1'b1;
      end
      return {sat, res[11:0]};
   endfunction

   function automatic logic [13:0] pick();
      case ($urandom_range(0, 7))
         0:       return 14'h1FFE;
         1:       return 14'h1FFF;
         2:       return 14'h2000;
         3:       return 14'h3FFA;
         default: return 14'($urandom);
      endcase
   endfunction

   typedef struct {
      logic [47:0] d;
      logic [3:0]  s;
   } exp_t;
   exp_t sb[$];

   initial begin
      int   exp_cnt;
      logic acc;
      exp_t e, got;
      logic [12:0] mr;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ovalid", u_ovalid, 1'b0);
      check("rst_odata", u_odata, 12'h000);
      check("rst_osat", u_osat, 1'b0);
      check("rst_cnt", u_cnt, 16'h0);
      check("rst_w_ovalid", w_ovalid, 1'b0);
      check("rst_w_cnt", w_cnt, 16'h0);
      rst = 1'b0;

      // 1: unsigned rounding modes
      run1(14'd6, ROUND_HALF_UP, 1'b0, "t1_hu6");
      check("t1_hu6", u_res, 12'd2);
      check("t1_hu6_sat", u_s, 1'b0);
      run1(14'd6, ROUND_HALF_EVEN, 1'b0, "t1_he6");
      check("t1_he6", u_res, 12'd2);
      run1(14'd6, ROUND_TRUNC, 1'b0, "t1_tr6");
      check("t1_tr6", u_res, 12'd1);
      run1(14'd10, ROUND_HALF_EVEN, 1'b0, "t1_he10");
      check("t1_he10", u_res, 12'd2);
      run1(14'd10, ROUND_HALF_UP, 1'b0, "t1_hu10");
      check("t1_hu10", u_res, 12'd3);

      // 2: saturation and clear priority
      run1(14'h3FFE, ROUND_HALF_UP, 1'b0, "t2_sat");
      check("t2_sat_data", u_res, 12'hFFF);
      check("t2_sat_flag", u_s, 1'b1);
      check("t2_cnt1", u_cnt, 16'd1);
      run1(14'h3FFE, ROUND_HALF_UP, 1'b1, "t2_clr");
      check("t2_clr_flag", u_s, 1'b1);
      check("t2_cnt0", u_cnt, 16'd0);

      // 3: signed lanes
      run1(14'h3FFA, ROUND_TRUNC, 1'b0, "t3_tr");
      check("t3_tr", s_res, 12'hFFE);
      run1(14'h3FFA, ROUND_HALF_UP, 1'b0, "t3_hu");
      check("t3_hu", s_res, 12'hFFF);
      run1(14'h3FFA, ROUND_TO_ZERO, 1'b0, "t3_tz");
      check("t3_tz", s_res, 12'hFFF);
      check("t3_tz_u", u_res, 12'hFFE);
      run1(14'h3FFA, ROUND_HALF_EVEN, 1'b0, "t3_he");
      check("t3_he", s_res, 12'hFFE);
      run1(14'h1FFE, ROUND_HALF_UP, 1'b0, "t3_sat");
      check("t3_sat_data", s_res, 12'h7FF);
      check("t3_sat_flag", s_s, 1'b1);
      check("t3_u_nosat", u_res, 12'h800);
      check("t3_u_nosat_flag", u_s, 1'b0);
      check("t3_s_cnt", s_cnt, 16'd1);

      // 4: backpressure with three beats offered
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 14'd20;
      in_mode   = ROUND_TRUNC;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_data = 14'd24;
      check("t4_rdy_b", u_iready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_data = 14'd28;
      check("t4_ovalid", u_ovalid, 1'b1);
      check("t4_rdy_c", u_iready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_hold_data", u_odata, 12'd5);
         check("t4_hold_rdy", u_iready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_b_valid", u_ovalid, 1'b1);
      check("t4_b_data", u_odata, 12'd6);
      @(negedge clk);
      check("t4_c_valid", u_ovalid, 1'b1);
      check("t4_c_data", u_odata, 12'd7);
      @(negedge clk);
      check("t4_drained", u_ovalid, 1'b0);

      // 5: four signed lanes, random stalls, scoreboard
      exp_cnt = 0;
      for (int cyc = 0; cyc < 320; cyc++) begin
         @(negedge clk);
         if (!w_ivalid) begin
            w_mode = 2'($urandom_range(0, 3));
            if (cyc < 290 && $urandom_range(0, 3) != 0) begin
               w_ivalid = 1'b1;
               for (int l = 0; l < 4; l++) w_idata[l*14 +: 14] = pick();
            end
         end
         w_oready = (cyc >= 290) || ($urandom_range(0, 2) != 0);
         #1;
         if (w_ovalid && w_oready) begin
            if (sb.size() == 0) begin
               check("t5_extra_beat", 1'b1, 1'b0);
            end else begin
               got = sb.pop_front();
               check("t5_data", w_odata, got.d);
               check("t5_sat", w_osat, got.s);
               if (got.s != 4'b0) exp_cnt++;
            end
         end
         acc = w_ivalid && w_iready;
         if (acc) begin
            for (int l = 0; l < 4; l++) begin
               mr = model_s(w_idata[l*14 +: 14], w_mode);
               e.d[l*12 +: 12] = mr[11:0];
               e.s[l] = mr[12];
            end
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         if (acc) w_ivalid = 1'b0;
      end
      check("t5_sb_empty", sb.size(), 0);
      check("t5_cnt", w_cnt, exp_cnt);

      // 6: asynchronous reset with both stages full
      run1(14'h3FFE, ROUND_HALF_UP, 1'b0, "t6_pre");
      check("t6_cnt1", u_cnt, 16'd1);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 14'd20;
      in_mode   = ROUND_TRUNC;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_data = 14'd24;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_full", u_ovalid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_ovalid", u_ovalid, 1'b0);
      check("t6_async_cnt", u_cnt, 16'd0);
      check("t6_async_data", u_odata, 12'd0);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      run1(14'd36, ROUND_TRUNC, 1'b0, "t6_post");
      check("t6_post", u_res, 12'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
